// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control blocks.
package core_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MULDIV_LAT_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // count events until the all-ones ceiling is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != '1)) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, mispredict flushes and mul/div freeze of the front end.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic             ex_hit,
  input  logic             ex_muldiv,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             redirect,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  state_e        state_r, next_state_s;
  logic [CW-1:0] cnt_r, next_cnt_s;
  logic          mispredict_s;
  logic          load_use_s;
  logic          stall_inc_s;

  assign mispredict_s = ex_is_branch & (ex_taken ^ ex_hit);
  assign load_use_s   = ex_memread & (ex_rt != REG_ZERO) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // output decode and next-state selection; reset overrides everything
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    redirect     = 1'b0;
    muldiv_done  = 1'b0;
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      next_state_s = RUN;
      next_cnt_s   = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (mispredict_s) begin
            redirect    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_write    = 1'b1;
          end else if (ex_muldiv) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            next_state_s = BUSY;
            next_cnt_s   = CW'(MULDIV_LAT - 2);
          end else if (load_use_s) begin
            // the bubble reaching EX drops ex_memread, so this clears itself
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            idex_write = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_r != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            next_cnt_s   = cnt_r - CW'(1'b1);
          end else begin
            // release cycle: ex_muldiv deliberately not looked at here
            muldiv_done  = 1'b1;
            next_state_s = RUN;
          end
        end
        default: begin
          next_state_s = RUN;
          next_cnt_s   = '0;
        end
      endcase
    end
  end

  // sequencer state and mul/div countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  assign stall_inc_s = ~rst & ~pc_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (flush_count)
  );

endmodule
